// File: rtl/clock_pkg.sv
// Shared constants, 7-segment glyphs and BCD helper for the time-of-day clock.
package clock_pkg;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  localparam int unsigned SEC_W  = $clog2(SEC_MAX + 1);
  localparam int unsigned MIN_W  = $clog2(MIN_MAX + 1);
  localparam int unsigned HOUR_W = $clog2(HOUR_MAX + 1);

  // Active-high glyphs, bit 0 = segment a
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_P     = 7'h73;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam logic [3:0] CODE_A     = 4'd10;
  localparam logic [3:0] CODE_P     = 4'd11;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // 0-99 binary to {tens, ones} BCD
  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One 7-segment digit decoder: 0-9, A (10), P (11), blank (15, and 12-14).
module bcd_to_7seg
  import clock_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] code,
  output logic [6:0] seg_c
);

  logic [6:0] glyph;

  always_comb begin
    glyph = GLYPH_BLANK;
    case (code)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      CODE_A:  glyph = GLYPH_A;
      CODE_P:  glyph = GLYPH_P;
      default: glyph = GLYPH_BLANK;
    endcase
  end

  assign seg_c = SEG_ACTIVE_LOW ? ~glyph : glyph;

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day counter with prescaler, set mode and 12/24h 8-digit display.
// Optional alarm comparator enabled by defining CLOCK_ALARM_EN.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 50_000_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned INIT_HOUR      = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set,
  input  logic [2:0]  up,
  input  logic        mode_ampm,
  output logic        clock_carry,
  output logic [23:0] time_bcd,
  output logic [55:0] clock_7seg
`ifdef CLOCK_ALARM_EN
  ,
  input  logic        alarm_on,
  input  logic [10:0] alarm_hm,
  output logic        alarm_hit
`endif
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  pre, pre_n;
  logic [SEC_W-1:0]  sec, sec_n, sec_inc;
  logic [MIN_W-1:0]  min, min_n, min_inc;
  logic [HOUR_W-1:0] hour, hour_n, hour_inc;
  logic              sec_wrap, min_wrap, hour_wrap;
  logic              carry_n;
  logic              ampm_mode;
  logic [2:0]        up_hist, up_rise;
  logic              ampm_hist;

  assign up_rise = up & ~up_hist;

  assign sec_wrap  = (sec == SEC_W'(SEC_MAX));
  assign min_wrap  = (min == MIN_W'(MIN_MAX));
  assign hour_wrap = (hour == HOUR_W'(HOUR_MAX));
  assign sec_inc   = sec_wrap ? '0 : sec + SEC_W'(1);
  assign min_inc   = min_wrap ? '0 : min + MIN_W'(1);
  assign hour_inc  = hour_wrap ? '0 : hour + HOUR_W'(1);

  // Set mode edits fields independently; run mode ripples carries on the tick
  always_comb begin
    pre_n   = pre;
    sec_n   = sec;
    min_n   = min;
    hour_n  = hour;
    carry_n = 1'b0;
    if (set) begin
      pre_n = '0;
      if (up_rise[0]) sec_n  = sec_inc;
      if (up_rise[1]) min_n  = min_inc;
      if (up_rise[2]) hour_n = hour_inc;
    end else if (pre == PRE_LAST) begin
      pre_n = '0;
      sec_n = sec_inc;
      if (sec_wrap) begin
        min_n = min_inc;
        if (min_wrap) begin
          hour_n  = hour_inc;
          carry_n = hour_wrap;
        end
      end
    end else begin
      pre_n = pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre         <= '0;
      sec         <= '0;
      min         <= '0;
      hour        <= HOUR_W'(INIT_HOUR);
      clock_carry <= 1'b0;
      ampm_mode   <= 1'b0;
      up_hist     <= '0;
      ampm_hist   <= 1'b0;
    end else begin
      pre         <= pre_n;
      sec         <= sec_n;
      min         <= min_n;
      hour        <= hour_n;
      clock_carry <= carry_n;
      ampm_mode   <= ampm_mode ^ (mode_ampm & ~ampm_hist);
      up_hist     <= up;
      ampm_hist   <= mode_ampm;
    end
  end

  logic [HOUR_W-1:0] hour_disp;
  logic              pm;
  logic [7:0]        ss_bcd, mm_bcd, hh_bcd, hd_bcd;
  logic [3:0]        codes [8];

  assign ss_bcd   = bin_to_bcd2(7'(sec));
  assign mm_bcd   = bin_to_bcd2(7'(min));
  assign hh_bcd   = bin_to_bcd2(7'(hour));
  assign hd_bcd   = bin_to_bcd2(7'(hour_disp));
  assign time_bcd = {hh_bcd, mm_bcd, ss_bcd};
  assign pm       = (hour >= HOUR_W'(12));

  // 12h display remaps 0 -> 12 and 13-23 -> 1-11 and blanks the leading zero
  always_comb begin
    hour_disp = hour;
    if (ampm_mode) begin
      if (hour == '0)                hour_disp = HOUR_W'(12);
      else if (hour > HOUR_W'(12))   hour_disp = hour - HOUR_W'(12);
    end
    codes[0] = ss_bcd[3:0];
    codes[1] = ss_bcd[7:4];
    codes[2] = mm_bcd[3:0];
    codes[3] = mm_bcd[7:4];
    codes[4] = hd_bcd[3:0];
    codes[5] = (ampm_mode && hd_bcd[7:4] == 4'd0) ? CODE_BLANK : hd_bcd[7:4];
    codes[6] = CODE_BLANK;
    codes[7] = ampm_mode ? (pm ? CODE_P : CODE_A) : CODE_BLANK;
  end

  for (genvar i = 0; i < 8; i++) begin : g_digit
    bcd_to_7seg #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg (
      .code  (codes[i]),
      .seg_c (clock_7seg[7*i +: 7])
    );
  end

`ifdef CLOCK_ALARM_EN
  logic alarm_in_range;

  assign alarm_in_range = (alarm_hm[10:6] <= 5'(HOUR_MAX)) && (alarm_hm[5:0] <= 6'(MIN_MAX));

  always_ff @(posedge clock) begin
    if (reset) alarm_hit <= 1'b0;
    else       alarm_hit <= alarm_on && !set && alarm_in_range && (alarm_hm == {hour, min});
  end
`endif

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper (TICK_DIV = 4, INIT_HOUR = 0, active-low segments).
module tb_clock_timekeeper;

  logic        clock = 1'b0;
  logic        reset;
  logic        set;
  logic [2:0]  up;
  logic        mode_ampm;
  logic        clock_carry;
  logic [23:0] time_bcd;
  logic [55:0] clock_7seg;
`ifdef CLOCK_ALARM_EN
  logic        alarm_on = 1'b0;
  logic [10:0] alarm_hm = '0;
  logic        alarm_hit;
`endif

  clock_timekeeper #(
    .TICK_DIV       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .INIT_HOUR      (0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .set         (set),
    .up          (up),
    .mode_ampm   (mode_ampm),
    .clock_carry (clock_carry),
    .time_bcd    (time_bcd),
    .clock_7seg  (clock_7seg)
`ifdef CLOCK_ALARM_EN
    ,
    .alarm_on    (alarm_on),
    .alarm_hm    (alarm_hm),
    .alarm_hit   (alarm_hit)
`endif
  );

  always #5 clock = ~clock;

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F;
  localparam logic [6:0] SA = 7'h77, SP = 7'h73, SB = 7'h00;

  localparam int K_TIME = 0, K_SEGHI = 1, K_CCNT = 2, K_CTIME = 3, K_CPREV = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          carry_cnt = 0;
  logic [23:0] carry_time = '0;
  logic [23:0] carry_prev = '0;
  logic [23:0] last_time  = '0;

  // Digits 7..4 as the bench expects them on active-low pins
  function automatic logic [31:0] segs(input logic [6:0] d7, d6, d5, d4);
    return {4'b0, ~d7, ~d6, ~d5, ~d4};
  endfunction

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_TIME:  return {8'b0, time_bcd};
      K_SEGHI: return {4'b0, clock_7seg[55:28]};
      K_CCNT:  return 32'(carry_cnt);
      K_CTIME: return {8'b0, carry_time};
      default: return {8'b0, carry_prev};
    endcase
  endfunction

  // Carry pulse tracker: count pulses and the time seen with/before each one
  always @(negedge clock) begin
    if (clock_carry === 1'b1) begin
      carry_cnt  = carry_cnt + 1;
      carry_time = time_bcd;
      carry_prev = last_time;
    end
    last_time = time_bcd;
  end

  // Monitor: drain every pending expectation against the DUT on the falling edge
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = observe(e.kind);
      n_cmp++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.tag, act, e.exp);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [2:0] bits);
    up = bits;
    step(1);
    up = 3'b000;
    step(1);
  endtask

  initial begin
    reset = 1'b1; set = 1'b0; up = 3'b000; mode_ampm = 1'b0;
    step(2);
    reset = 1'b0;
    expect_val("reset_time", K_TIME, 32'h000000);
    expect_val("reset_segs", K_SEGHI, segs(SB, SB, S0, S0));
    step(1);

    // Free run: 4 x 60 cycles = one minute
    step(239);
    expect_val("run_1min", K_TIME, 32'h000100);
    expect_val("run_no_carry", K_CCNT, 32'd0);

    // Set to 23:59:58 with simultaneous field edges
    set = 1'b1;
    for (int k = 0; k < 58; k++) pulse({k < 23, 1'b1, 1'b1});
    expect_val("set_235958", K_TIME, 32'h235958);
    expect_val("set_no_carry", K_CCNT, 32'd0);

    // Release set: rollover after 8 cycles
    set = 1'b0;
    step(8);
    expect_val("rollover", K_TIME, 32'h000000);
    step(1);
    expect_val("carry_count", K_CCNT, 32'd1);
    expect_val("carry_time", K_CTIME, 32'h000000);
    expect_val("carry_prev", K_CPREV, 32'h235959);

    // 61 minute increments wrap to 01, no carry into hour
    set = 1'b1;
    for (int k = 0; k < 61; k++) pulse(3'b010);
    expect_val("min_wrap", K_TIME, 32'h000100);
    expect_val("min_wrap_carry", K_CCNT, 32'd1);

    // Prescaler held at 0 in set mode: first tick TICK_DIV cycles after release
    set = 1'b0;
    step(3);
    expect_val("release_3", K_TIME, 32'h000100);
    step(1);
    expect_val("release_4", K_TIME, 32'h000101);

    // 12h display
    set = 1'b1;
    mode_ampm = 1'b1;
    step(1);
    expect_val("ampm_12A", K_SEGHI, segs(SA, SB, S1, S2));
    for (int k = 0; k < 13; k++) pulse(3'b100);
    expect_val("ampm_1P", K_SEGHI, segs(SP, SB, SB, S1));
    expect_val("ampm_time24", K_TIME, 32'h130101);
    mode_ampm = 1'b0;
    step(1);
    mode_ampm = 1'b1;
    step(1);
    expect_val("back_24h", K_SEGHI, segs(SB, SB, S1, S3));

    // up edge with set low is ignored; set on the tick cycle suppresses it
    set = 1'b0;
    up = 3'b100;
    step(1);
    up = 3'b000;
    step(2);
    expect_val("up_ignored", K_TIME, 32'h130101);
    set = 1'b1;
    step(1);
    expect_val("set_wins_tick", K_TIME, 32'h130101);
    set = 1'b0;
    step(3);
    expect_val("restart_3", K_TIME, 32'h130101);
    step(1);
    expect_val("restart_4", K_TIME, 32'h130102);

    // Drive to 12:34:56 and show 12P
    set = 1'b1;
    for (int k = 0; k < 54; k++) pulse({k < 23, k < 33, 1'b1});
    expect_val("set_123456", K_TIME, 32'h123456);
    mode_ampm = 1'b0;
    step(1);
    mode_ampm = 1'b1;
    step(1);
    expect_val("ampm_12P", K_SEGHI, segs(SP, SB, S1, S2));

    // Reset mid-count with up[0] held: one edge counted after release
    mode_ampm = 1'b0;
    up = 3'b001;
    reset = 1'b1;
    step(1);
    expect_val("reset_mid", K_TIME, 32'h000000);
    expect_val("reset_mode24", K_SEGHI, segs(SB, SB, S0, S0));
    reset = 1'b0;
    step(1);
    expect_val("held_edge", K_TIME, 32'h000001);
    step(2);
    expect_val("held_once", K_TIME, 32'h000001);
    expect_val("final_carry", K_CCNT, 32'd1);
    up = 3'b000;

    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
        step(1);
        budget++;
      end
      if (sb.size() > 0) begin
        n_fail++;
        $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
